// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants and types for the memory arbiter.
//   - funct3 load/store width encodings (B/H/W/BU/HU)
//   - IO address prefix (addr[17:16]) used for UART back-pressure
//   - FSM state encoding and a helper giving transfer length from a width
package mem_arbiter_pkg;

  localparam logic [2:0] WidthLb  = 3'b000;
  localparam logic [2:0] WidthLh  = 3'b001;
  localparam logic [2:0] WidthLw  = 3'b010;
  localparam logic [2:0] WidthLbu = 3'b100;
  localparam logic [2:0] WidthLhu = 3'b101;

  localparam logic [1:0] IoPrefix = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

  // Number of bytes moved for an lsb access of the given funct3 width.
  function automatic logic [2:0] ls_len(input logic [2:0] width);
    case (width)
      WidthLb, WidthLbu: return 3'd1;
      WidthLh, WidthLhu: return 3'd2;
      default:           return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the byte-wide RAM/IO bus and both requester ports.
//   master modport: the arbiter (drives memory pins and done/data returns)
//   slave  modport: the environment (RAM/IO, icache and lsb)
//   mem_*      : byte address/data/write strobe, mem_din one cycle after address
//   ic_*       : icache fetch request (level) and done/data return
//   ls_*       : lsb load/store request (level) and done/data return
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;
  logic                  io_buffer_full;

  logic                  ic_req;
  logic [ADDR_WIDTH-1:0] ic_addr;
  logic                  ic_done;
  logic [31:0]           ic_data;

  logic                  ls_req;
  logic                  ls_store;
  logic [2:0]            ls_width;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [31:0]           ls_wdata;
  logic                  ls_done;
  logic [31:0]           ls_rdata;

  modport master (
    input  mem_din, io_buffer_full,
    input  ic_req, ic_addr,
    input  ls_req, ls_store, ls_width, ls_addr, ls_wdata,
    output mem_dout, mem_a, mem_wr,
    output ic_done, ic_data,
    output ls_done, ls_rdata
  );

  modport slave (
    output mem_din, io_buffer_full,
    output ic_req, ic_addr,
    output ls_req, ls_store, ls_width, ls_addr, ls_wdata,
    input  mem_dout, mem_a, mem_wr,
    input  ic_done, ic_data,
    input  ls_done, ls_rdata
  );

endinterface

// File: rtl/mem_extend.sv
// mem_extend: combinational load-result formatting.
//   i_lanes : assembled little-endian byte lanes
//   i_width : funct3 width (B/H sign-extend, BU/HU zero-extend, W passthrough)
//   o_data  : extended 32-bit load result
module mem_extend
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] i_lanes,
  input  logic [2:0]  i_width,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_lanes;
    case (i_width)
      WidthLb:  o_data = {{24{i_lanes[7]}}, i_lanes[7:0]};
      WidthLh:  o_data = {{16{i_lanes[15]}}, i_lanes[15:0]};
      WidthLbu: o_data = {24'd0, i_lanes[7:0]};
      WidthLhu: o_data = {16'd0, i_lanes[15:0]};
      default:  o_data = i_lanes;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM/IO bus between icache and lsb.
//   clk_in, rst_in : clock, synchronous active-high reset
//   rdy_in         : global ready, low freezes every register
//   clear_all      : pipeline flush, aborts reads, never aborts stores
//   HALT           : sets a sticky halt; no further grants until reset
//   bus            : memory pins plus icache/lsb request and return ports
// Round-robin grant, one byte per cycle, load extension via mem_extend.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned FETCH_BYTES = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_all,
  input  logic             HALT,
  mem_arbiter_if.master    bus
);

  state_e                r_state, w_state_next;
  logic [2:0]            r_cnt, w_cnt_next;
  logic [2:0]            r_len, w_len_next;
  logic [ADDR_WIDTH-1:0] r_base, w_base_next;
  logic                  r_is_ic, w_is_ic_next;
  logic                  r_store, w_store_next;
  logic [2:0]            r_width, w_width_next;
  logic [3:0][7:0]       r_wdata, w_wdata_next;
  logic [3:0][7:0]       r_lanes, w_lanes_next;
  logic                  r_last_ic, w_last_ic_next;
  logic                  r_halted, w_halted_next;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [1:0]            w_lane;
  logic                  w_io_stall;
  logic                  w_blocked;
  logic                  w_gnt_ic;
  logic                  w_gnt_ls;
  logic                  w_flush;
  logic [31:0]           w_ls_rdata;

  assign w_addr     = r_base + ADDR_WIDTH'(r_cnt);
  // Byte returned this cycle belongs to the address driven one cycle earlier.
  assign w_lane     = r_cnt[1:0] - 2'd1;
  assign w_io_stall = (w_addr[17:16] == IoPrefix) && bus.io_buffer_full;
  assign w_blocked  = clear_all || r_halted || HALT;
  // On a tie, the requester that was not served last wins.
  assign w_gnt_ic   = !w_blocked && bus.ic_req && (!bus.ls_req || !r_last_ic);
  assign w_gnt_ls   = !w_blocked && bus.ls_req && (!bus.ic_req || r_last_ic);
  // Stores are committed at the rob head, so a flush never cancels them.
  assign w_flush    = clear_all && !r_store;

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_len_next     = r_len;
    w_base_next    = r_base;
    w_is_ic_next   = r_is_ic;
    w_store_next   = r_store;
    w_width_next   = r_width;
    w_wdata_next   = r_wdata;
    w_lanes_next   = r_lanes;
    w_last_ic_next = r_last_ic;
    w_halted_next  = r_halted || HALT;
    bus.mem_a      = '0;
    bus.mem_wr     = 1'b0;
    bus.mem_dout   = 8'd0;
    bus.ic_done    = 1'b0;
    bus.ls_done    = 1'b0;

    case (r_state)
      StIdle: begin
        if (w_gnt_ic) begin
          w_base_next    = bus.ic_addr;
          w_len_next     = 3'(FETCH_BYTES);
          w_is_ic_next   = 1'b1;
          w_store_next   = 1'b0;
          w_width_next   = WidthLw;
          w_cnt_next     = 3'd0;
          w_lanes_next   = '0;
          w_last_ic_next = 1'b1;
          w_state_next   = StRead;
        end else if (w_gnt_ls) begin
          w_base_next    = bus.ls_addr;
          w_len_next     = ls_len(bus.ls_width);
          w_is_ic_next   = 1'b0;
          w_store_next   = bus.ls_store;
          w_width_next   = bus.ls_width;
          w_wdata_next   = bus.ls_wdata;
          w_cnt_next     = 3'd0;
          w_lanes_next   = '0;
          w_last_ic_next = 1'b0;
          w_state_next   = bus.ls_store ? StWrite : StRead;
        end
      end
      StRead: begin
        if (r_cnt < r_len) bus.mem_a = w_addr;
        if (r_cnt != 3'd0) w_lanes_next[w_lane] = bus.mem_din;
        if (clear_all) begin
          w_state_next = StIdle;
        end else if (r_cnt == r_len) begin
          w_state_next = StDone;
        end else begin
          w_cnt_next = r_cnt + 3'd1;
        end
      end
      StWrite: begin
        bus.mem_a    = w_addr;
        bus.mem_dout = r_wdata[r_cnt[1:0]];
        if (!w_io_stall) begin
          bus.mem_wr = 1'b1;
          if (r_cnt == r_len - 3'd1) begin
            w_state_next = StDone;
          end else begin
            w_cnt_next = r_cnt + 3'd1;
          end
        end
      end
      StDone: begin
        bus.ic_done  = r_is_ic && !w_flush;
        bus.ls_done  = !r_is_ic && !w_flush;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= StIdle;
      r_cnt     <= 3'd0;
      r_len     <= 3'd0;
      r_base    <= '0;
      r_is_ic   <= 1'b0;
      r_store   <= 1'b0;
      r_width   <= 3'd0;
      r_wdata   <= '0;
      r_lanes   <= '0;
      r_last_ic <= 1'b0;
      r_halted  <= 1'b0;
    end else if (rdy_in) begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_len     <= w_len_next;
      r_base    <= w_base_next;
      r_is_ic   <= w_is_ic_next;
      r_store   <= w_store_next;
      r_width   <= w_width_next;
      r_wdata   <= w_wdata_next;
      r_lanes   <= w_lanes_next;
      r_last_ic <= w_last_ic_next;
      r_halted  <= w_halted_next;
    end
  end

  mem_extend u_extend (
    .i_lanes (r_lanes),
    .i_width (r_width),
    .o_data  (w_ls_rdata)
  );

  assign bus.ic_data  = r_lanes;
  assign bus.ls_rdata = w_ls_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// A small byte RAM with one-cycle read latency sits on the memory pins;
// writes to addr[17:16]==2'b11 are logged as UART bytes instead.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  logic clear_all = 1'b0;
  logic halt = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  bit mon_en = 1'b1;
  bit ic_hold = 1'b0, ls_hold = 1'b0;
  bit ic_done_prev = 1'b0, ls_done_prev = 1'b0;

  logic [7:0] ram [0:4095];
  int         io_wr_count = 0;
  logic [7:0] io_last = 8'd0;

  mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32), .FETCH_BYTES(4)) dut (
    .clk_in    (clk),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .clear_all (clear_all),
    .HALT      (halt),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // RAM/IO model, paused by rdy_in like the real memory.
  always @(posedge clk) begin
    if (rdy_in) begin
      if (bus.mem_wr) begin
        if (bus.mem_a[17:16] == 2'b11) begin
          io_wr_count = io_wr_count + 1;
          io_last = bus.mem_dout;
        end else begin
          ram[bus.mem_a[11:0]] = bus.mem_dout;
        end
      end
      bus.mem_din <= ram[bus.mem_a[11:0]];
    end
  end

  // Requests must be held until done or flush; sampled just before each posedge.
  always begin
    @(negedge clk);
    #4;
    if (rst_in || !mon_en) begin
      ic_hold = 1'b0;
      ls_hold = 1'b0;
    end else begin
      if (ic_hold) begin
        n_total++;
        if (!bus.ic_req && !bus.ic_done && !clear_all)
          $display("FAIL ic_req_held got=%b exp=1", bus.ic_req);
        else n_pass++;
      end
      if (ls_hold) begin
        n_total++;
        if (!bus.ls_req && !bus.ls_done && !clear_all)
          $display("FAIL ls_req_held got=%b exp=1", bus.ls_req);
        else n_pass++;
      end
      ic_hold = bus.ic_req && !bus.ic_done && !clear_all && !ic_done_prev;
      ls_hold = bus.ls_req && !bus.ls_done && !clear_all && !ls_done_prev;
    end
    ic_done_prev = bus.ic_done;
    ls_done_prev = bus.ls_done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    clear_all = 1'b0;
    halt = 1'b0;
    bus.ic_req = 1'b0;
    bus.ic_addr = '0;
    bus.ls_req = 1'b0;
    bus.ls_store = 1'b0;
    bus.ls_width = 3'd0;
    bus.ls_addr = '0;
    bus.ls_wdata = '0;
    bus.io_buffer_full = 1'b0;
    repeat (2) @(negedge clk);
    rst_in = 1'b0;
  endtask

  task automatic issue_ls(input logic store, input logic [2:0] width,
                          input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus.ls_req = 1'b1;
    bus.ls_store = store;
    bus.ls_width = width;
    bus.ls_addr = addr;
    bus.ls_wdata = wdata;
  endtask

  // Waits for a done pulse; cyc = cycles after the request cycle, -1 on timeout.
  task automatic wait_done(input bit want_ic, input int bound, output int cyc);
    bit seen = 1'b0;
    int k = 0;
    cyc = -1;
    while (!seen && k < bound) begin
      @(negedge clk);
      #1;
      k++;
      if (want_ic ? bus.ic_done : bus.ls_done) begin
        seen = 1'b1;
        cyc = k;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_total++;
    if (bus.mem_wr !== 1'b0 || bus.mem_a !== 32'd0 || bus.mem_dout !== 8'd0)
      $display("FAIL reset_bus got=%b/%h/%h exp=0/0/0", bus.mem_wr, bus.mem_a, bus.mem_dout);
    else n_pass++;
    n_total++;
    if (bus.ic_done !== 1'b0 || bus.ls_done !== 1'b0 || bus.ic_data !== 32'd0 ||
        bus.ls_rdata !== 32'd0)
      $display("FAIL reset_ret got=%b/%b/%h/%h exp=0/0/0/0", bus.ic_done, bus.ls_done,
               bus.ic_data, bus.ls_rdata);
    else n_pass++;
  endtask

  task automatic test_fetch();
    apply_reset();
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    @(negedge clk);
    bus.ic_req = 1'b1;
    bus.ic_addr = 32'h100;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #1;
      if (k <= 4) begin
        n_total++;
        if (bus.mem_a !== 32'h100 + k - 1 || bus.mem_wr !== 1'b0)
          $display("FAIL fetch_addr k=%0d got=%h/%b exp=%h/0", k, bus.mem_a, bus.mem_wr,
                   32'h100 + k - 1);
        else n_pass++;
      end
      if (k == 5) begin
        n_total++;
        if (bus.ic_done !== 1'b0) $display("FAIL fetch_early got=%b exp=0", bus.ic_done);
        else n_pass++;
      end
      if (k == 6) begin
        n_total++;
        if (bus.ic_done !== 1'b1 || bus.ic_data !== 32'h0000_0513)
          $display("FAIL fetch_done got=%b/%h exp=1/00000513", bus.ic_done, bus.ic_data);
        else n_pass++;
        bus.ic_req = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    n_total++;
    if (bus.ic_done !== 1'b0 || bus.mem_a !== 32'd0)
      $display("FAIL fetch_pulse got=%b/%h exp=0/0", bus.ic_done, bus.mem_a);
    else n_pass++;
  endtask

  task automatic test_contention();
    int cyc;
    apply_reset();
    ram[12'h300] = 8'haa; ram[12'h301] = 8'hbb; ram[12'h302] = 8'hcc; ram[12'h303] = 8'hdd;
    ram[12'h400] = 8'h7f;
    @(negedge clk);
    bus.ic_req = 1'b1;
    bus.ic_addr = 32'h300;
    bus.ls_req = 1'b1;
    bus.ls_store = 1'b0;
    bus.ls_width = WidthLbu;
    bus.ls_addr = 32'h400;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #1;
      if (k == 1) begin
        n_total++;
        if (bus.mem_a !== 32'h300) $display("FAIL tie_first got=%h exp=00000300", bus.mem_a);
        else n_pass++;
      end
      if (k == 6) begin
        n_total++;
        if (bus.ic_done !== 1'b1 || bus.ic_data !== 32'hddcc_bbaa)
          $display("FAIL tie_ic_done got=%b/%h exp=1/ddccbbaa", bus.ic_done, bus.ic_data);
        else n_pass++;
      end
      if (k == 8) begin
        n_total++;
        if (bus.mem_a !== 32'h400) $display("FAIL tie_second got=%h exp=00000400", bus.mem_a);
        else n_pass++;
        bus.ic_req = 1'b0;
      end
    end
    wait_done(1'b0, 20, cyc);
    n_total++;
    if (cyc !== 2 || bus.ls_rdata !== 32'h0000_007f)
      $display("FAIL tie_ls_done got=%0d/%h exp=2/0000007f", cyc, bus.ls_rdata);
    else n_pass++;
    bus.ls_req = 1'b0;
  endtask

  task automatic test_signed_loads();
    logic [2:0]  w_tab [5] = '{WidthLb, WidthLbu, WidthLh, WidthLhu, WidthLw};
    logic [31:0] e_tab [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FF80, 32'h0000_FF80,
                               32'h3412_FF80};
    int          l_tab [5] = '{3, 3, 4, 4, 6};
    int cyc;
    apply_reset();
    ram[12'h200] = 8'h80; ram[12'h201] = 8'hFF; ram[12'h202] = 8'h12; ram[12'h203] = 8'h34;
    for (int i = 0; i < 5; i++) begin
      issue_ls(1'b0, w_tab[i], 32'h200, 32'd0);
      wait_done(1'b0, 20, cyc);
      n_total++;
      if (cyc !== l_tab[i]) $display("FAIL load_lat i=%0d got=%0d exp=%0d", i, cyc, l_tab[i]);
      else n_pass++;
      n_total++;
      if (bus.ls_rdata !== e_tab[i])
        $display("FAIL load_data i=%0d got=%h exp=%h", i, bus.ls_rdata, e_tab[i]);
      else n_pass++;
      bus.ls_req = 1'b0;
    end
  endtask

  task automatic test_io_store();
    apply_reset();
    io_wr_count = 0;
    issue_ls(1'b1, WidthLb, 32'h0003_0000, 32'h0000_0041);
    bus.io_buffer_full = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 4) bus.io_buffer_full = 1'b0;
      #1;
      if (k <= 3) begin
        n_total++;
        if (bus.mem_wr !== 1'b0) $display("FAIL io_stall k=%0d got=%b exp=0", k, bus.mem_wr);
        else n_pass++;
      end
      if (k == 4) begin
        n_total++;
        if (bus.mem_wr !== 1'b1 || bus.mem_dout !== 8'h41 || bus.mem_a !== 32'h0003_0000)
          $display("FAIL io_write got=%b/%h/%h exp=1/41/00030000", bus.mem_wr, bus.mem_dout,
                   bus.mem_a);
        else n_pass++;
      end
      if (k == 5) begin
        n_total++;
        if (bus.ls_done !== 1'b1) $display("FAIL io_done got=%b exp=1", bus.ls_done);
        else n_pass++;
        bus.ls_req = 1'b0;
      end
    end
    n_total++;
    if (io_wr_count !== 1 || io_last !== 8'h41)
      $display("FAIL io_log got=%0d/%h exp=1/41", io_wr_count, io_last);
    else n_pass++;
  endtask

  task automatic test_flush();
    int cyc;
    bit seen;
    apply_reset();
    // Fetch aborted in its third cycle.
    @(negedge clk);
    bus.ic_req = 1'b1;
    bus.ic_addr = 32'h100;
    repeat (2) @(negedge clk);
    @(negedge clk);
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
    bus.ic_req = 1'b0;
    #1;
    n_total++;
    if (bus.mem_a !== 32'd0 || bus.ic_done !== 1'b0)
      $display("FAIL flush_idle got=%h/%b exp=0/0", bus.mem_a, bus.ic_done);
    else n_pass++;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (bus.ic_done) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL flush_no_done got=%b exp=0", seen);
    else n_pass++;

    // Load flushed in its DONE cycle.
    ram[12'h200] = 8'h80;
    issue_ls(1'b0, WidthLb, 32'h200, 32'd0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    clear_all = 1'b1;
    #1;
    n_total++;
    if (bus.ls_done !== 1'b0) $display("FAIL flush_load_done got=%b exp=0", bus.ls_done);
    else n_pass++;
    @(negedge clk);
    clear_all = 1'b0;
    bus.ls_req = 1'b0;
    #1;
    n_total++;
    if (bus.ls_done !== 1'b0 || bus.mem_a !== 32'd0)
      $display("FAIL flush_load_idle got=%b/%h exp=0/0", bus.ls_done, bus.mem_a);
    else n_pass++;

    // Store ignores a flush.
    issue_ls(1'b1, WidthLw, 32'h500, 32'hDEAD_BEEF);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 2) clear_all = 1'b1;
      if (k == 4) clear_all = 1'b0;
      #1;
      if (k <= 4) begin
        n_total++;
        if (bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h500 + k - 1)
          $display("FAIL flush_sw_wr k=%0d got=%b/%h exp=1/%h", k, bus.mem_wr, bus.mem_a,
                   32'h500 + k - 1);
        else n_pass++;
      end
      if (k == 5) begin
        n_total++;
        if (bus.ls_done !== 1'b1) $display("FAIL flush_sw_done got=%b exp=1", bus.ls_done);
        else n_pass++;
        bus.ls_req = 1'b0;
      end
    end
    n_total++;
    if ({ram[12'h503], ram[12'h502], ram[12'h501], ram[12'h500]} !== 32'hDEAD_BEEF)
      $display("FAIL flush_sw_ram got=%h exp=deadbeef",
               {ram[12'h503], ram[12'h502], ram[12'h501], ram[12'h500]});
    else n_pass++;
    cyc = 0;
  endtask

  task automatic test_rdy_stall();
    int cyc = -1;
    apply_reset();
    ram[12'h300] = 8'haa; ram[12'h301] = 8'hbb; ram[12'h302] = 8'hcc; ram[12'h303] = 8'hdd;
    @(negedge clk);
    bus.ic_req = 1'b1;
    bus.ic_addr = 32'h300;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 2) rdy_in = 1'b0;
      if (k == 7) rdy_in = 1'b1;
      #1;
      if (bus.ic_done && cyc < 0) begin
        cyc = k;
        n_total++;
        if (bus.ic_data !== 32'hddcc_bbaa)
          $display("FAIL rdy_data got=%h exp=ddccbbaa", bus.ic_data);
        else n_pass++;
        bus.ic_req = 1'b0;
      end
    end
    n_total++;
    if (cyc !== 11) $display("FAIL rdy_latency got=%0d exp=11", cyc);
    else n_pass++;
  endtask

  task automatic test_halt();
    int cyc;
    bit seen_ic, seen_ls, seen_bus;
    apply_reset();
    ram[12'h200] = 8'h80;
    issue_ls(1'b0, WidthLb, 32'h200, 32'd0);
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    wait_done(1'b0, 10, cyc);
    n_total++;
    if (cyc !== 1 || bus.ls_rdata !== 32'hFFFF_FF80)
      $display("FAIL halt_load got=%0d/%h exp=1/ffffff80", cyc, bus.ls_rdata);
    else n_pass++;
    bus.ls_req = 1'b0;
    mon_en = 1'b0;
    @(negedge clk);
    bus.ic_req = 1'b1;
    bus.ic_addr = 32'h100;
    bus.ls_req = 1'b1;
    seen_ic = 1'b0; seen_ls = 1'b0; seen_bus = 1'b0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (bus.ic_done) seen_ic = 1'b1;
      if (bus.ls_done) seen_ls = 1'b1;
      if (bus.mem_a !== 32'd0) seen_bus = 1'b1;
    end
    n_total++;
    if ({seen_ic, seen_ls, seen_bus} !== 3'b000)
      $display("FAIL halt_no_grant got=%b exp=000", {seen_ic, seen_ls, seen_bus});
    else n_pass++;
    bus.ic_req = 1'b0;
    bus.ls_req = 1'b0;
    mon_en = 1'b1;
    // Reset releases the halt.
    apply_reset();
    issue_ls(1'b0, WidthLbu, 32'h200, 32'd0);
    wait_done(1'b0, 10, cyc);
    n_total++;
    if (cyc !== 3 || bus.ls_rdata !== 32'h0000_0080)
      $display("FAIL halt_released got=%0d/%h exp=3/00000080", cyc, bus.ls_rdata);
    else n_pass++;
    bus.ls_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05;
    @(negedge clk);
    bus.ic_req = 1'b1;
    bus.ic_addr = 32'h100;
    repeat (3) @(negedge clk);
    rst_in = 1'b1;
    bus.ic_req = 1'b0;
    @(negedge clk);
    #1;
    n_total++;
    if (bus.mem_a !== 32'd0 || bus.mem_wr !== 1'b0 || bus.ic_done !== 1'b0 ||
        bus.ic_data !== 32'd0)
      $display("FAIL reset_mid got=%h/%b/%b/%h exp=0/0/0/0", bus.mem_a, bus.mem_wr,
               bus.ic_done, bus.ic_data);
    else n_pass++;
    rst_in = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'd0;
    bus.mem_din = 8'd0;
    test_reset();
    test_fetch();
    test_contention();
    test_signed_loads();
    test_io_store();
    test_flush();
    test_rdy_stall();
    test_halt();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
